// File: rtl/running_time_display_module_pkg.sv
// Shared widths, glyph codes/patterns and FSM states for the running-time display.
// Optional feature macro (used in the top): BLANK_LEADING_ZERO_EN.
package running_time_display_module_pkg;

   localparam int MAX_WIDTH    = 32;
   localparam int COUNTER_1SEC = 99_999_999;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_HRS,
      ST_MIN,
      ST_BCD,
      ST_COMMIT
   } disp_state_t;

   // 4-bit glyph codes fed to the decoder; 0-9 are the digits themselves
   localparam logic [3:0] CODE_C     = 4'hA;
   localparam logic [3:0] CODE_T     = 4'hB;
   localparam logic [3:0] CODE_BLANK = 4'hF;

   // Segment patterns {g,f,e,d,c,b,a}, active-high
   localparam logic [6:0] SEG_0     = 7'h3F;
   localparam logic [6:0] SEG_1     = 7'h06;
   localparam logic [6:0] SEG_2     = 7'h5B;
   localparam logic [6:0] SEG_3     = 7'h4F;
   localparam logic [6:0] SEG_4     = 7'h66;
   localparam logic [6:0] SEG_5     = 7'h6D;
   localparam logic [6:0] SEG_6     = 7'h7D;
   localparam logic [6:0] SEG_7     = 7'h07;
   localparam logic [6:0] SEG_8     = 7'h7F;
   localparam logic [6:0] SEG_9     = 7'h6F;
   localparam logic [6:0] SEG_C     = 7'h39;
   localparam logic [6:0] SEG_T     = 7'h78;
   localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/running_time_display_module_if.sv
// Display-side signal bundle: time inputs and selection in, scanned segments and busy out.
interface running_time_display_module_if;
   import running_time_display_module_pkg::*;

   logic                 sel_total;
   logic [MAX_WIDTH-1:0] current_running_time;
   logic [MAX_WIDTH-1:0] total_running_time;
   logic [7:0]           seg_en;
   logic [7:0]           seg_out;
   logic                 busy;

   modport master (
      output sel_total, current_running_time, total_running_time,
      input  seg_en, seg_out, busy
   );

   modport slave (
      input  sel_total, current_running_time, total_running_time,
      output seg_en, seg_out, busy
   );

endinterface

// File: rtl/running_time_display_module_seg7_decoder.sv
// Combinational glyph-code to 7-segment pattern decoder.
module running_time_display_module_seg7_decoder
   import running_time_display_module_pkg::*;
(
   input  logic [3:0] i_code,
   output logic [6:0] o_seg
);

   always_comb begin
      o_seg = SEG_BLANK;
      case (i_code)
         4'd0:    o_seg = SEG_0;
         4'd1:    o_seg = SEG_1;
         4'd2:    o_seg = SEG_2;
         4'd3:    o_seg = SEG_3;
         4'd4:    o_seg = SEG_4;
         4'd5:    o_seg = SEG_5;
         4'd6:    o_seg = SEG_6;
         4'd7:    o_seg = SEG_7;
         4'd8:    o_seg = SEG_8;
         4'd9:    o_seg = SEG_9;
         CODE_C:  o_seg = SEG_C;
         CODE_T:  o_seg = SEG_T;
         default: o_seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/running_time_display_module.sv
// Snapshots current/total running seconds, converts to HH:MM:SS BCD, scans an 8-digit display.
// Define BLANK_LEADING_ZERO_EN to blank leading zero hour digits.
module running_time_display_module
   import running_time_display_module_pkg::*;
#(
   parameter int SAMPLE_DIV = COUNTER_1SEC + 1,
   parameter int SCAN_DIV   = 100000
)
(
   input  logic                          clk,
   input  logic                          rst,
   running_time_display_module_if.slave  disp_bus
);

   localparam int SMW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
   localparam int SCW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [MAX_WIDTH-1:0] SECS_HOUR = MAX_WIDTH'(3600);
   localparam logic [MAX_WIDTH-1:0] SECS_MIN  = MAX_WIDTH'(60);

   disp_state_t          r_state, w_state_nxt;
   logic [SMW-1:0]       r_sample_cnt;
   logic [MAX_WIDTH-1:0] r_rem;
   logic                 r_sel, r_sat, r_busy;
   logic [6:0]           r_hrs, r_min, r_sec;
   logic [3:0]           r_ht, r_mt, r_st;
   logic [3:0]           r_disp_h1, r_disp_h0, r_disp_m1, r_disp_m0, r_disp_s1, r_disp_s0;
   logic                 r_disp_sel;

   logic [SCW-1:0]       r_scan_cnt;
   logic [2:0]           r_digit_idx;
   logic [7:0]           r_seg_en, r_seg_out;

   logic                 w_snap, w_ge_hour, w_ge_min, w_hrs_room, w_bcd_done, w_scan_wrap;
   logic [2:0]           w_idx_nxt;
   logic [3:0]           w_code, w_h1_code, w_h0_code;
   logic [6:0]           w_seg7;

   assign w_snap     = (r_sample_cnt == '0) && (r_state == ST_IDLE);
   assign w_ge_hour  = r_rem >= SECS_HOUR;
   assign w_ge_min   = r_rem >= SECS_MIN;
   assign w_hrs_room = r_hrs < 7'd99;
   assign w_bcd_done = (r_hrs < 7'd10) && (r_min < 7'd10) && (r_sec < 7'd10);

   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:   if (w_snap) w_state_nxt = ST_LOAD;
         ST_LOAD:   w_state_nxt = ST_HRS;
         ST_HRS:    if (!(w_ge_hour && w_hrs_room)) w_state_nxt = ST_MIN;
         ST_MIN:    if (r_sat || !w_ge_min) w_state_nxt = ST_BCD;
         ST_BCD:    if (w_bcd_done) w_state_nxt = ST_COMMIT;
         ST_COMMIT: w_state_nxt = ST_IDLE;
         default:   w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sample_cnt <= '0;
         r_busy       <= 1'b0;
         r_rem        <= '0;
         r_sel        <= 1'b0;
         r_sat        <= 1'b0;
         r_hrs        <= '0;
         r_min        <= '0;
         r_sec        <= '0;
         r_ht         <= '0;
         r_mt         <= '0;
         r_st         <= '0;
         r_disp_h1    <= '0;
         r_disp_h0    <= '0;
         r_disp_m1    <= '0;
         r_disp_m0    <= '0;
         r_disp_s1    <= '0;
         r_disp_s0    <= '0;
         r_disp_sel   <= 1'b0;
      end else begin
         r_sample_cnt <= (r_sample_cnt == SMW'(SAMPLE_DIV - 1)) ? '0 : r_sample_cnt + SMW'(1);
         r_busy       <= (w_state_nxt != ST_IDLE);
         case (r_state)
            ST_LOAD: begin
               r_rem <= disp_bus.sel_total ? disp_bus.total_running_time
                                           : disp_bus.current_running_time;
               r_sel <= disp_bus.sel_total;
               r_sat <= 1'b0;
               r_hrs <= '0;
               r_min <= '0;
               r_sec <= '0;
               r_ht  <= '0;
               r_mt  <= '0;
               r_st  <= '0;
            end
            ST_HRS: begin
               if (w_ge_hour && w_hrs_room) begin
                  r_rem <= r_rem - SECS_HOUR;
                  r_hrs <= r_hrs + 7'd1;
               end else if (w_ge_hour) begin
                  r_sat <= 1'b1;
               end
            end
            ST_MIN: begin
               // Saturated inputs skip the minute loop entirely and pin the display at 99:59:59
               if (r_sat) begin
                  r_min <= 7'd59;
                  r_sec <= 7'd59;
               end else if (w_ge_min) begin
                  r_rem <= r_rem - SECS_MIN;
                  r_min <= r_min + 7'd1;
               end else begin
                  r_sec <= r_rem[6:0];
               end
            end
            ST_BCD: begin
               if (r_hrs >= 7'd10) begin r_hrs <= r_hrs - 7'd10; r_ht <= r_ht + 4'd1; end
               if (r_min >= 7'd10) begin r_min <= r_min - 7'd10; r_mt <= r_mt + 4'd1; end
               if (r_sec >= 7'd10) begin r_sec <= r_sec - 7'd10; r_st <= r_st + 4'd1; end
            end
            ST_COMMIT: begin
               r_disp_h1  <= r_ht;
               r_disp_h0  <= r_hrs[3:0];
               r_disp_m1  <= r_mt;
               r_disp_m0  <= r_min[3:0];
               r_disp_s1  <= r_st;
               r_disp_s0  <= r_sec[3:0];
               r_disp_sel <= r_sel;
            end
            default: ;
         endcase
      end
   end

`ifdef BLANK_LEADING_ZERO_EN
   assign w_h1_code = (r_disp_h1 == 4'd0) ? CODE_BLANK : r_disp_h1;
   assign w_h0_code = (r_disp_h1 == 4'd0 && r_disp_h0 == 4'd0) ? CODE_BLANK : r_disp_h0;
`else
   assign w_h1_code = r_disp_h1;
   assign w_h0_code = r_disp_h0;
`endif

   assign w_scan_wrap = (r_scan_cnt == SCW'(SCAN_DIV - 1));
   assign w_idx_nxt   = r_digit_idx + 3'd1;

   // The mux looks ahead to the next digit so seg_en and seg_out load on the same edge
   always_comb begin
      w_code = CODE_BLANK;
      case (w_idx_nxt)
         3'd7:    w_code = r_disp_sel ? CODE_T : CODE_C;
         3'd6:    w_code = CODE_BLANK;
         3'd5:    w_code = w_h1_code;
         3'd4:    w_code = w_h0_code;
         3'd3:    w_code = r_disp_m1;
         3'd2:    w_code = r_disp_m0;
         3'd1:    w_code = r_disp_s1;
         default: w_code = r_disp_s0;
      endcase
   end

   running_time_display_module_seg7_decoder u_seg7 (
      .i_code (w_code),
      .o_seg  (w_seg7)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_scan_cnt  <= '0;
         r_digit_idx <= '0;
         r_seg_en    <= 8'b0000_0001;
         r_seg_out   <= '0;
      end else if (w_scan_wrap) begin
         r_scan_cnt  <= '0;
         r_digit_idx <= w_idx_nxt;
         r_seg_en    <= 8'd1 << w_idx_nxt;
         r_seg_out   <= {(w_idx_nxt == 3'd4) || (w_idx_nxt == 3'd2), w_seg7};
      end else begin
         r_scan_cnt  <= r_scan_cnt + SCW'(1);
      end
   end

   assign disp_bus.seg_en  = r_seg_en;
   assign disp_bus.seg_out = r_seg_out;
   assign disp_bus.busy    = r_busy;

endmodule

// File: tb/tb_running_time_display_module.sv
// Directed + randomized bench for running_time_display_module against an arithmetic HH:MM:SS model.
module tb_running_time_display_module;

   logic clk;
   logic rst;
   int   checks;
   int   failures;
   logic [7:0] cap [8];

   running_time_display_module_if ifc ();

   running_time_display_module #(
      .SAMPLE_DIV (400),
      .SCAN_DIV   (4)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .disp_bus (ifc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         failures++;
         $error("FAIL %s got=%0h exp=%0h", tag, obs, exp_v);
      end
   endtask

   function automatic logic [7:0] glyph(input int code);
      logic [6:0] tbl [12];
      tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F, 7'h39, 7'h78};
      if (code < 0 || code > 11) return 8'h00;
      return {1'b0, tbl[code]};
   endfunction

   // Expected segment byte for digit idx when the display shows x seconds
   function automatic logic [7:0] exp_seg(input int idx, input int unsigned x, input bit sel);
      int h, m, s;
      int code [8];
      logic [7:0] p;
      if (x >= 360000) begin
         h = 99; m = 59; s = 59;
      end else begin
         h = x / 3600; m = (x / 60) % 60; s = x % 60;
      end
      code[7] = sel ? 11 : 10;
      code[6] = -1;
      code[5] = h / 10;
      code[4] = h % 10;
      code[3] = m / 10;
      code[2] = m % 10;
      code[1] = s / 10;
      code[0] = s % 10;
`ifdef BLANK_LEADING_ZERO_EN
      if (h / 10 == 0) code[5] = -1;
      if (h == 0)      code[4] = -1;
`endif
      p = glyph(code[idx]);
      p[7] = (idx == 4) || (idx == 2);
      return p;
   endfunction

   task automatic wait_busy(input logic val, input string tag);
      int c = 0;
      while (ifc.busy !== val && c < 2000) begin
         @(negedge clk);
         c++;
      end
      check({tag, "_busy_wait"}, 32'(c < 2000), 32'd1);
   endtask

   task automatic capture(input string tag);
      bit got [8];
      logic [7:0] prev;
      int n = 0;
      for (int i = 0; i < 8; i++) got[i] = 1'b0;
      prev = ifc.seg_en;
      for (int c = 0; c < 200 && n < 8; c++) begin
         @(negedge clk);
         if (ifc.seg_en !== prev) begin
            for (int i = 0; i < 8; i++) begin
               if (ifc.seg_en[i] === 1'b1 && !got[i]) begin
                  got[i] = 1'b1;
                  cap[i] = ifc.seg_out;
                  n++;
               end
            end
            prev = ifc.seg_en;
         end
      end
      check({tag, "_capture"}, 32'(n), 32'd8);
   endtask

   task automatic verify(input int unsigned x, input bit sel, input string tag);
      for (int i = 0; i < 8; i++)
         check($sformatf("%s_d%0d", tag, i), 32'(cap[i]), 32'(exp_seg(i, x, sel)));
   endtask

   task automatic apply(input bit sel, input int unsigned cur, input int unsigned tot, input string tag);
      wait_busy(1'b0, {tag, "_idle"});
      ifc.sel_total            = sel;
      ifc.current_running_time = cur;
      ifc.total_running_time   = tot;
   endtask

   task automatic do_conv(input bit sel, input int unsigned cur, input int unsigned tot, input string tag);
      apply(sel, cur, tot, tag);
      wait_busy(1'b1, {tag, "_start"});
      wait_busy(1'b0, {tag, "_done"});
      capture(tag);
      verify(sel ? tot : cur, sel, tag);
   endtask

   initial begin
      int unsigned a, b, x, y;
      bit s;
      checks   = 0;
      failures = 0;
      rst = 1'b1;
      ifc.sel_total            = 1'b0;
      ifc.current_running_time = '0;
      ifc.total_running_time   = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("reset_busy",    32'(ifc.busy),    32'd0);
      check("reset_seg_en",  32'(ifc.seg_en),  32'h01);
      check("reset_seg_out", 32'(ifc.seg_out), 32'h00);

      // Scan walk: one digit step every 4 cycles from reset release
      for (int k = 0; k < 40; k++) begin
         check($sformatf("scan_k%0d", k), 32'(ifc.seg_en), 32'(8'd1 << ((k / 4) % 8)));
         @(negedge clk);
      end
      wait_busy(1'b0, "zero");
      capture("zero");
      verify(0, 1'b0, "zero");

      do_conv(1'b0, 3725, 0, "cur3725");
      do_conv(1'b1, 12, 360005, "tot_sat");
      do_conv(1'b1, 0, 359999, "tot_359999");
      do_conv(1'b0, 59, 0, "cur59");
      do_conv(1'b0, 60, 0, "cur60");
      do_conv(1'b0, 65, 0, "cur65");

      // Inputs and selection changing mid-conversion must not leak into the result
      apply(1'b0, 7384, 1234, "midchg");
      wait_busy(1'b1, "midchg_start");
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         ifc.sel_total            = ~ifc.sel_total;
         ifc.current_running_time = $urandom_range(0, 400000);
         ifc.total_running_time   = $urandom_range(0, 400000);
      end
      wait_busy(1'b0, "midchg_done");
      capture("midchg");
      verify(7384, 1'b0, "midchg");

      // Reset held 3 cycles in the middle of a long conversion
      apply(1'b1, 0, 359000, "rstmid");
      wait_busy(1'b1, "rstmid_start");
      repeat (5) @(negedge clk);
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("rstmid_busy",    32'(ifc.busy),    32'd0);
      check("rstmid_seg_en",  32'(ifc.seg_en),  32'h01);
      check("rstmid_seg_out", 32'(ifc.seg_out), 32'h00);
      wait_busy(1'b1, "rstmid_restart");
      wait_busy(1'b0, "rstmid_redone");
      capture("rstmid");
      verify(359000, 1'b1, "rstmid");

      for (int r = 0; r < 8; r++) begin
         s = 1'($urandom_range(0, 1));
         a = $urandom_range(0, 420000);
         b = $urandom_range(0, 420000);
         x = s ? b : a;
         y = s ? a : b;
         if (s) do_conv(s, y, x, $sformatf("rnd%0d", r));
         else   do_conv(s, x, y, $sformatf("rnd%0d", r));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
